// File: rtl/axis_uart_pkg.sv
// Shared definitions for the AXIS-UART path (TX now, RX later).
// Optional even-parity bit enabled by defining AXIS_UART_TX_PARITY_EN.
package axis_uart_pkg;

  localparam logic UART_IDLE_LEVEL           = 1'b1;
  localparam int   UART_CLKS_PER_BIT_DEFAULT = 16;

`ifdef AXIS_UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_tx_state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd4
  } uart_tx_state_t;
`endif

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the terminal count.
// Held at zero while clear is high so a new frame starts on a clean period.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic bit_tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CNT_W-1:0] count;

  assign bit_tick = (count == CNT_W'(CLKS_PER_BIT - 1));

  // Baud counter: clear to zero, otherwise count and wrap at terminal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear || bit_tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/axis_uart_tx.sv
// AXI-Stream slave to UART transmitter. One byte held per frame; s_axis_ready
// stays low for the whole frame. tx and s_axis_ready are registered, driven
// from the next-state decode so tx changes on the same edge as the state.
// Define AXIS_UART_TX_PARITY_EN to insert an even-parity bit after the data.
module axis_uart_tx
  import axis_uart_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] s_axis_data,
  input  logic             s_axis_valid,
  output logic             s_axis_ready,
  output logic             tx,
  output logic             tx_busy,
  output logic             frame_done
);

  localparam int IDX_W = $clog2(WIDTH);

  uart_tx_state_t   state;
  uart_tx_state_t   state_nx;
  logic [WIDTH-1:0] shift;
  logic [IDX_W-1:0] bit_idx;
  logic             bit_tick;
  logic             accept;
  logic             last_bit;
  logic             advance;
  logic             tx_d;
  logic             ready_d;
`ifdef AXIS_UART_TX_PARITY_EN
  logic             parity_bit;
`endif

  assign accept   = s_axis_valid && s_axis_ready;
  assign last_bit = (bit_idx == IDX_W'(WIDTH - 1));
  assign advance  = (state == ST_DATA) && bit_tick && !last_bit;

  assign tx_busy    = (state != ST_IDLE);
  assign frame_done = (state == ST_STOP) && bit_tick;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state == ST_IDLE),
    .bit_tick(bit_tick)
  );

  // State register; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state decode: every non-idle state lasts one bit period.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (accept) state_nx = ST_START;
      ST_START: if (bit_tick) state_nx = ST_DATA;
`ifdef AXIS_UART_TX_PARITY_EN
      ST_DATA:   if (bit_tick && last_bit) state_nx = ST_PARITY;
      ST_PARITY: if (bit_tick) state_nx = ST_STOP;
`else
      ST_DATA:  if (bit_tick && last_bit) state_nx = ST_STOP;
`endif
      ST_STOP:  if (bit_tick) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Output decode from the next state; within DATA a bit advance exposes shift[1].
  always_comb begin
    tx_d    = UART_IDLE_LEVEL;
    ready_d = (state_nx == ST_IDLE);
    case (state_nx)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = advance ? shift[1] : shift[0];
`ifdef AXIS_UART_TX_PARITY_EN
      ST_PARITY: tx_d = parity_bit;
`endif
      default:   tx_d = UART_IDLE_LEVEL;
    endcase
  end

  // Registered pad outputs; ready stays low during reset and rises one edge later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx           <= UART_IDLE_LEVEL;
      s_axis_ready <= 1'b0;
    end else begin
      tx           <= tx_d;
      s_axis_ready <= ready_d;
    end
  end

  // Bit index: restart at handshake, step on each data bit boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_idx <= '0;
    end else if (accept) begin
      bit_idx <= '0;
    end else if (advance) begin
      bit_idx <= bit_idx + 1'b1;
    end
  end

  // Holding/shift register: loaded only on handshake, so mid-frame input changes are ignored.
  always_ff @(posedge clk) begin
    if (accept) begin
      shift <= s_axis_data;
`ifdef AXIS_UART_TX_PARITY_EN
      parity_bit <= ^s_axis_data;
`endif
    end else if (advance) begin
      shift <= shift >> 1;
    end
  end

endmodule

// File: tb/tb_axis_uart_tx.sv
// Directed bench for axis_uart_tx (WIDTH=8, CLKS_PER_BIT=4).
// Follows AXIS_UART_TX_PARITY_EN to choose the expected frame layout.
module tb_axis_uart_tx;

  localparam int W = 8;
  localparam int C = 4;
`ifdef AXIS_UART_TX_PARITY_EN
  localparam int NSLOT = W + 3;
`else
  localparam int NSLOT = W + 2;
`endif
  localparam int F = NSLOT * C;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] s_axis_data;
  logic         s_axis_valid;
  logic         s_axis_ready;
  logic         tx;
  logic         tx_busy;
  logic         frame_done;

  int tests;
  int fails;

  axis_uart_tx #(
    .WIDTH       (W),
    .CLKS_PER_BIT(C)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_axis_data (s_axis_data),
    .s_axis_valid(s_axis_valid),
    .s_axis_ready(s_axis_ready),
    .tx          (tx),
    .tx_busy     (tx_busy),
    .frame_done  (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] data;
    logic       par;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Expected line level for frame slot (start, data LSB first, [parity], stop).
  function automatic logic exp_bit(input logic [7:0] d, input logic par, input int slot);
    if (slot == 0) return 1'b0;
    if (slot <= W) return d[slot-1];
`ifdef AXIS_UART_TX_PARITY_EN
    if (slot == W + 1) return par;
    return 1'b1;
`else
    // stop level; the parity argument only matters when a parity slot exists
    return 1'b1 | par;
`endif
  endfunction

  task automatic wait_ready(input string nm);
    int n = 0;
    while (s_axis_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_ready_wait"}, 32'(s_axis_ready), 32'd1);
  endtask

  // Called at a negedge with the handshake set up for the coming posedge.
  // Returns at the negedge of the cycle after the frame (the idle gap cycle).
  task automatic capture(input logic [7:0] d, input logic par, input string nm,
                         input bit drop, input bit mid_ff);
    int         bad   = 0;
    int         rlow  = 0;
    int         dcnt  = 0;
    int         nbusy = 0;
    bit         dlast = 1'b0;
    logic [7:0] dec   = '0;
    logic       psmp  = 1'b0;
    for (int i = 0; i < F; i++) begin
      @(negedge clk);
      if (drop && i == 0) s_axis_valid = 1'b0;
      if (mid_ff && i == 3 * C) begin
        s_axis_data  = 8'hFF;
        s_axis_valid = 1'b1;
      end
      if (tx !== exp_bit(d, par, i / C)) bad++;
      if (i % C == C / 2) begin
        if (i / C >= 1 && i / C <= W) dec[i/C-1] = tx;
        if (i / C == W + 1) psmp = tx;
      end
      if (s_axis_ready === 1'b0) rlow++;
      if (tx_busy !== 1'b1) nbusy++;
      if (frame_done === 1'b1) begin
        dcnt++;
        if (i == F - 1) dlast = 1'b1;
      end
    end
    check({nm, "_tx_cycles_bad"}, 32'(bad), 32'd0);
    check({nm, "_decoded"}, 32'(dec), 32'(d));
`ifdef AXIS_UART_TX_PARITY_EN
    check({nm, "_parity"}, 32'(psmp), 32'(par));
`endif
    check({nm, "_ready_low_cycles"}, 32'(rlow), 32'(F));
    check({nm, "_busy_gaps"}, 32'(nbusy), 32'd0);
    check({nm, "_done_pulses"}, 32'(dcnt), 32'd1);
    check({nm, "_done_on_last"}, 32'(dlast), 32'd1);
    @(negedge clk);
    check({nm, "_ready_after"}, 32'(s_axis_ready), 32'd1);
    check({nm, "_tx_gap"}, 32'(tx), 32'd1);
    check({nm, "_busy_after"}, 32'(tx_busy), 32'd0);
  endtask

  initial begin
    int bad_idle;
    tests = 0;
    fails = 0;

    vecs[0] = '{data: 8'h55, par: 1'b0};
    vecs[1] = '{data: 8'h07, par: 1'b1};
    vecs[2] = '{data: 8'h03, par: 1'b0};
    vecs[3] = '{data: 8'hA5, par: 1'b0};
    vecs[4] = '{data: 8'h80, par: 1'b1};

    // Reset state
    rst_n        = 1'b0;
    s_axis_valid = 1'b0;
    s_axis_data  = '0;
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_ready", 32'(s_axis_ready), 32'd0);
    check("rst_busy", 32'(tx_busy), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    rst_n = 1'b1;
    #1 check("rel_ready_before_edge", 32'(s_axis_ready), 32'd0);
    @(negedge clk);
    check("rel_ready_first_edge", 32'(s_axis_ready), 32'd1);

    // Idle with no valid for 100 cycles
    bad_idle = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_busy !== 1'b0 || frame_done !== 1'b0) bad_idle++;
    end
    check("idle_100_bad", 32'(bad_idle), 32'd0);

    // Table-driven single frames
    for (int k = 0; k < 5; k++) begin
      wait_ready($sformatf("vec%0d", k));
      s_axis_data  = vecs[k].data;
      s_axis_valid = 1'b1;
      capture(vecs[k].data, vecs[k].par, $sformatf("vec%0d_%02h", k, vecs[k].data), 1'b1, 1'b0);
    end

    // Back-to-back with valid held: one idle cycle, then the next start bit
    wait_ready("b2b");
    s_axis_data  = 8'h48;
    s_axis_valid = 1'b1;
    capture(8'h48, 1'b0, "b2b_48", 1'b0, 1'b0);
    s_axis_data = 8'h45;
    capture(8'h45, 1'b1, "b2b_45", 1'b1, 1'b0);

    // Data/valid changes mid-frame are ignored
    wait_ready("midff");
    s_axis_data  = 8'h00;
    s_axis_valid = 1'b1;
    capture(8'h00, 1'b0, "midff_00", 1'b1, 1'b1);
    s_axis_valid = 1'b0;

    // Reset during data bit 3 (first cycle of slot 4)
    wait_ready("abort");
    s_axis_data  = 8'hF0;
    s_axis_valid = 1'b1;
    for (int i = 0; i < 4 * C + 1; i++) begin
      @(negedge clk);
      if (i == 0) s_axis_valid = 1'b0;
    end
    check("abort_pre_tx_bit3", 32'(tx), 32'd0);
    check("abort_pre_busy", 32'(tx_busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_tx", 32'(tx), 32'd1);
    check("abort_busy", 32'(tx_busy), 32'd0);
    check("abort_ready", 32'(s_axis_ready), 32'd0);
    check("abort_done", 32'(frame_done), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_ready_after_release", 32'(s_axis_ready), 32'd1);
    check("abort_tx_idle", 32'(tx), 32'd1);
    s_axis_data  = 8'hA5;
    s_axis_valid = 1'b1;
    capture(8'hA5, 1'b0, "post_abort_a5", 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
